// File: rtl/clock_period_meter_pkg.sv
// Shared definitions for clock_period_meter: FSM state encoding and default counter width.
package clock_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/clock_period_meter_edge_sync_detect.sv
// Rising-edge detector with optional 2-flop synchronizer in front (PERIOD_METER_SYNC_EN).
module edge_sync_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic s;
  logic s_prev_q;
  logic s_prev_d;

`ifdef PERIOD_METER_SYNC_EN
  logic sync1_q;
  logic sync1_d;
  logic sync2_q;
  logic sync2_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = sig_in;
`endif

  assign s_prev_d = s;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev_q <= 1'b0;
    end else begin
      s_prev_q <= s_prev_d;
    end
  end

  assign rise = s & ~s_prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures sig_in rising-edge-to-rising-edge period in clk cycles, one result per start.
// Define PERIOD_METER_SYNC_EN to insert a 2-flop synchronizer on sig_in.
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             period_valid,
  input  logic             period_ready,
  output logic [WIDTH-1:0] period,
  output logic             overflow,
  output state_t           state_dbg
);

  // Result handshake: a transfer happens on a cycle where period_valid && period_ready;
  // period/overflow are stable while period_valid is high and not yet accepted.

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             overflow_q, overflow_d;
  logic             rise;

  edge_sync_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    overflow_d = overflow_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (rise) begin
          state_d = ST_COUNT;
          count_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      ST_COUNT: begin
        // A real edge on the saturating cycle still reports a genuine period.
        if (rise) begin
          state_d    = ST_DONE;
          period_d   = count_q;
          overflow_d = 1'b0;
        end else if (count_q == COUNT_MAX) begin
          state_d    = ST_DONE;
          period_d   = COUNT_MAX;
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (period_ready) state_d = start ? ST_ARM : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      period_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy         = (state_q == ST_ARM) || (state_q == ST_COUNT);
  assign period_valid = (state_q == ST_DONE);
  assign period       = period_q;
  assign overflow     = overflow_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized scoreboard bench for clock_period_meter driven by periodic square waves.
module tb_clock_period_meter;
  import clock_period_meter_pkg::*;

  localparam int W    = 8;
  localparam int EW   = W + 1;
  localparam int MAXP = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         sig_in;
  logic         start;
  logic         period_ready;
  logic         busy;
  logic         period_valid;
  logic [W-1:0] period;
  logic         overflow;
  state_t       state_dbg;

  always #5 clk = ~clk;

  clock_period_meter #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .start        (start),
    .busy         (busy),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .period       (period),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  logic [EW-1:0] exp_q[$];
  int n_checks  = 0;
  int n_pass    = 0;
  int n_issued  = 0;
  int n_results = 0;

  // Waveform generator state: 0 = held low, 1 = periodic, 2 = held high.
  int wave_mode = 0;
  int wave_p    = 4;
  int wave_hi   = 2;
  int phase     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: period P is reported exactly if it fits, otherwise saturates with overflow.
  function automatic logic [EW-1:0] model(input int p);
    logic [W-1:0] all_ones;
    logic [W-1:0] pv;
    all_ones = '1;
    pv = p[W-1:0];
    if (p > MAXP) return {1'b1, all_ones};
    return {1'b0, pv};
  endfunction

  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wave_mode)
        0: sig_in = 1'b0;
        2: sig_in = 1'b1;
        default: begin
          phase  = (phase + 1) % wave_p;
          sig_in = (phase < wave_hi);
        end
      endcase
    end
  end

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && period_valid && period_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("period", 32'(period), 32'(e[W-1:0]));
        check("overflow", 32'(overflow), 32'(e[W]));
      end
      n_results++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wave(input int p, input int hi);
    wave_p    = p;
    wave_hi   = hi;
    phase     = 0;
    wave_mode = 1;
    cycles(p + 8);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic issue(input logic [EW-1:0] e);
    exp_q.push_back(e);
    n_issued++;
  endtask

  task automatic wait_results();
    int cyc;
    cyc = 0;
    while (n_results < n_issued && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (n_results < n_issued) begin
      check("result_timeout", 32'(n_results), 32'(n_issued));
      n_results = n_issued;
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input state_t s);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while (state_dbg != s && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (state_dbg != s) check("state_timeout", 32'(state_dbg), 32'(s));
  endtask

  task automatic measure(input int p, input int hi);
    set_wave(p, hi);
    issue(model(p));
    pulse_start();
    wait_results();
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    period_ready = 1'b1;
    start        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(period_valid), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    cycles(3);

    // Divider-like ratios, then exact-fit and just-too-long periods.
    measure(2, 1);
    measure(4, 2);
    measure(8, 4);
    measure(16, 8);
    measure(MAXP, $urandom_range(1, MAXP - 1));
    measure(MAXP + 1, $urandom_range(1, MAXP));

    // Random periods and duty cycles.
    for (int i = 0; i < 8; i++) begin
      int p;
      p = $urandom_range(2, 40);
      measure(p, $urandom_range(1, p - 1));
    end

    // One rising edge then stuck high: saturation.
    wave_mode = 0;
    cycles(6);
    issue(model(MAXP + 1));
    pulse_start();
    cycles(3);
    wave_mode = 2;
    wait_results();

    // Result held stable under backpressure while sig_in keeps toggling.
    period_ready = 1'b0;
    set_wave(10, 3);
    issue(model(10));
    pulse_start();
    wait_state(ST_DONE);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(period_valid), 32'd1);
      check("hold_period", 32'(period), 32'(exp_q[0][W-1:0]));
    end
    @(posedge clk); #1;
    period_ready = 1'b1;
    wait_results();

    // start during COUNT is ignored: one result, then idle.
    set_wave(12, 6);
    issue(model(12));
    pulse_start();
    wait_state(ST_COUNT);
    @(posedge clk); #1;
    pulse_start();
    wait_results();
    repeat (10) @(negedge clk);
    check("single_state", 32'(state_dbg), 32'(ST_IDLE));
    check("single_busy", 32'(busy), 32'd0);
    check("single_valid", 32'(period_valid), 32'd0);

    // start together with ready in DONE re-arms directly.
    period_ready = 1'b0;
    set_wave(6, 2);
    issue(model(6));
    pulse_start();
    wait_state(ST_DONE);
    @(posedge clk); #1;
    issue(model(6));
    start        = 1'b1;
    period_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rearm_state", 32'(state_dbg), 32'(ST_ARM));
    check("rearm_busy", 32'(busy), 32'd1);
    wait_results();

    // Reset mid-COUNT aborts the measurement.
    set_wave(30, 15);
    issue(model(30));
    pulse_start();
    wait_state(ST_COUNT);
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    void'(exp_q.pop_front());
    n_issued--;
    @(negedge clk);
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(period_valid), 32'd0);
    check("abort_period", 32'(period), 32'd0);
    check("abort_overflow", 32'(overflow), 32'd0);
    cycles(2);
    measure(7, 3);

    cycles(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("result_count", 32'(n_results), 32'(n_issued));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
